// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit engine.
// Holds the one-hot FSM state encodings and the legal parameter ranges.
package uart_pkg;

    // One-hot transmit FSM states; exposed on the debug port as raw bits.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } uart_state_t;

    // Legal parameter ranges for the engine.
    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 9;
    localparam int CLKS_PER_BIT_MIN = 2;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

    // Width of the shared data/stop bit counter (covers up to 9 data bits).
    localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-cycle counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_end on the last
// cycle of every serial bit; clear holds it at zero.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running wrap counter, held at zero while cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
    end

    assign bit_end = enable && !clear && (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: double-buffered UART transmitter (holding + shift register).
// Optional parity bit is compiled in with the macro UART_TX_PARITY_EN.
// Handshake: a byte is taken on a rising clk edge where tx_valid && tx_ready;
// tx_ready means the holding register is empty; tx_data is sampled only then.
// txd and frame_done are registered, so the line lags the FSM by one cycle.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 tx_enable,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done,
    output logic [4:0]           o_dbg_state
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        CLKS_PER_BIT < CLKS_PER_BIT_MIN ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_params
        $error("uart_tx_engine: parameter outside legal range");
    end

    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_next_state;
    logic [DATA_BITS-1:0]   r_hold_data;
    logic                   r_hold_full;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_txd;
    logic                   r_done_d;
    logic                   r_frame_done;
    logic                   w_bit_end;
    logic                   w_start_ok;
    logic                   w_stop_end;
    logic                   w_load;
    logic                   w_accept;
    logic                   w_last_data;
    logic                   w_txd_nxt;

    assign w_accept    = tx_valid && !r_hold_full;
    assign w_start_ok  = r_hold_full && tx_enable;
    assign w_last_data = (r_bit_cnt == LAST_DATA);
    assign w_stop_end  = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
    assign w_load      = ((r_state == ST_IDLE) || w_stop_end) && w_start_ok;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == ST_IDLE),
        .enable  (r_state != ST_IDLE),
        .bit_end (w_bit_end)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; STOP chains straight into START when a byte waits
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_START;
            ST_START: if (w_bit_end) w_next_state = ST_DATA;
            ST_DATA: begin
                if (w_bit_end && w_last_data) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = ST_PARITY;
`else
                    w_next_state = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_bit_end) w_next_state = ST_STOP;
`endif
            ST_STOP:  if (w_stop_end) w_next_state = w_start_ok ? ST_START : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Holding register: filled on accept, freed when the shifter loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= tx_data;
        end
    end

    // Shift register: LSB is the bit on the line during DATA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= r_hold_data;
        end else if ((r_state == ST_DATA) && w_bit_end) begin
            r_shift <= r_shift >> 1;
        end
    end

    // Bit counter shared by DATA (data bits) and STOP (stop bits)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (w_bit_end && (r_state == ST_DATA)) begin
            r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
        end else if (w_bit_end && (r_state == ST_STOP)) begin
            r_bit_cnt <= (r_bit_cnt == LAST_STOP) ? '0 : r_bit_cnt + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity computed once from the byte being loaded into the shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= (^r_hold_data) ^ (PARITY_ODD != 0);
        end
    end
`else
    logic w_unused_parity_cfg;
    assign w_unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // FSM output decode: line level for the current state
    always_comb begin
        w_txd_nxt = 1'b1;
        case (r_state)
            ST_START:  w_txd_nxt = 1'b0;
            ST_DATA:   w_txd_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_nxt = r_parity;
`endif
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    // Registered line and completion pulse; done lands just after the last stop cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txd        <= 1'b1;
            r_done_d     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_txd        <= w_txd_nxt;
            r_done_d     <= w_stop_end;
            r_frame_done <= r_done_d;
        end
    end

    assign txd         = r_txd;
    assign frame_done  = r_frame_done;
    assign tx_ready    = !r_hold_full;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed bench for uart_tx_engine.
// Instance A: 8 data bits, 1 stop, even parity; instance B: 5 data bits,
// 2 stops, odd parity; both at 4 clocks per bit. Parity follows UART_TX_PARITY_EN.
module tb_uart_tx_engine;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [7:0] tx_data_a;
    logic       tx_valid_a;
    logic       tx_enable_a;
    logic       tx_ready_a, txd_a, busy_a, frame_done_a;
    logic [4:0] dbg_state_a;

    logic [4:0] tx_data_b;
    logic       tx_valid_b;
    logic       tx_enable_b;
    logic       tx_ready_b, txd_b, busy_b, frame_done_b;
    logic [4:0] dbg_state_b;

    uart_tx_engine #(
        .DATA_BITS (8), .CLKS_PER_BIT (CPB), .STOP_BITS (1), .PARITY_ODD (0)
    ) dut_a (
        .clk (clk), .rst (rst), .tx_data (tx_data_a), .tx_valid (tx_valid_a),
        .tx_ready (tx_ready_a), .tx_enable (tx_enable_a), .txd (txd_a),
        .busy (busy_a), .frame_done (frame_done_a), .o_dbg_state (dbg_state_a)
    );

    uart_tx_engine #(
        .DATA_BITS (5), .CLKS_PER_BIT (CPB), .STOP_BITS (2), .PARITY_ODD (1)
    ) dut_b (
        .clk (clk), .rst (rst), .tx_data (tx_data_b), .tx_valid (tx_valid_b),
        .tx_ready (tx_ready_b), .tx_enable (tx_enable_b), .txd (txd_b),
        .busy (busy_b), .frame_done (frame_done_b), .o_dbg_state (dbg_state_b)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_qa[$];
    logic [15:0] exp_qb[$];
    int errors = 0;
    int checks = 0;
    int frames[2] = '{0, 0};
    int b2b[2]    = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial image of one frame, index = bit position on the line (start first).
    function automatic logic [15:0] frame_model(input int nb, input int odd, input logic [8:0] d);
        logic [15:0] v;
        logic        p;
        v    = '1;
        v[0] = 1'b0;
        p    = (odd != 0);
        for (int i = 0; i < nb; i++) begin
            v[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (PAR == 1) v[1 + nb] = p;
        return v;
    endfunction

    function automatic logic get_txd(input int id);
        return (id == 0) ? txd_a : txd_b;
    endfunction

    function automatic logic get_done(input int id);
        return (id == 0) ? frame_done_a : frame_done_b;
    endfunction

    function automatic logic get_ready(input int id);
        return (id == 0) ? tx_ready_a : tx_ready_b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int id, input logic [8:0] d, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        if (id == 0) begin tx_data_a = d[7:0]; tx_valid_a = 1'b1; end
        else         begin tx_data_b = d[4:0]; tx_valid_b = 1'b1; end
        while (get_ready(id) == 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("accept_ready%0d", id), get_ready(id), 1);
        @(posedge clk);
        if (id == 0) exp_qa.push_back(frame_model(8, 0, d));
        else         exp_qb.push_back(frame_model(5, 1, d));
        @(negedge clk);
        acc = cyc;
        if (id == 0) begin tx_valid_a = 1'b0; tx_data_a = 8'($urandom_range(0, 255)); end
        else         begin tx_valid_b = 1'b0; tx_data_b = 5'($urandom_range(0, 31)); end
    endtask

    task automatic wait_frames(input int id, input int n);
        int t;
        t = 0;
        while (frames[id] < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("frame_count%0d", id), frames[id], n);
    endtask

    // ---------------- line monitor ----------------
    task automatic monitor(input int id, input int nbits);
        logic        prev, in_frame, aborted, early;
        logic [15:0] rx, bad, e;
        int          flen;
        flen = nbits * CPB;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            in_frame = !rst && prev && !get_txd(id);
            prev     = rst ? 1'b1 : get_txd(id);
            while (in_frame) begin
                rx = '1; bad = '0; aborted = 1'b0; early = 1'b0;
                for (int c = 0; c < flen; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    if (c % CPB == 0) rx[c / CPB] = get_txd(id);
                    else if (get_txd(id) !== rx[c / CPB]) bad[c / CPB] = 1'b1;
                    if (c > 0 && get_done(id)) early = 1'b1;
                end
                if (aborted) begin
                    in_frame = 1'b0;
                    prev     = 1'b1;
                end else begin
                    @(negedge clk);
                    if (rst) begin
                        in_frame = 1'b0;
                        prev     = 1'b1;
                    end else begin
                        check($sformatf("frame_done_pulse%0d", id), get_done(id), 1);
                        check($sformatf("frame_done_quiet%0d", id), early, 0);
                        check($sformatf("bit_duration%0d", id), bad, 0);
                        if (id == 0) begin
                            check("frame_queued0", (exp_qa.size() > 0), 1);
                            if (exp_qa.size() > 0) begin
                                e = exp_qa.pop_front();
                                check("frame_bits0", rx, e);
                            end
                        end else begin
                            check("frame_queued1", (exp_qb.size() > 0), 1);
                            if (exp_qb.size() > 0) begin
                                e = exp_qb.pop_front();
                                check("frame_bits1", rx, e);
                            end
                        end
                        frames[id]++;
                        in_frame = !get_txd(id);
                        if (in_frame) b2b[id]++;
                        prev = get_txd(id);
                    end
                end
            end
        end
    endtask

    initial monitor(0, 1 + 8 + PAR + 1);
    initial monitor(1, 1 + 5 + PAR + 2);

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int  acc, acc2, b2b_before, t;
        logic ok_a, ok_b;
        tx_data_a   = '0;
        tx_valid_a  = 1'b0;
        tx_enable_a = 1'b1;
        tx_data_b   = '0;
        tx_valid_b  = 1'b0;
        tx_enable_b = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", txd_a, 1);
        check("rst_ready", tx_ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", frame_done_a, 0);
        check("rst_state", dbg_state_a, 5'b00001);
        check("rst_txd_b", txd_b, 1);
        rst = 1'b0;

        // 0xA5 with first-byte latency: accept N, load N+1, start bit from N+2
        send(0, 9'h0A5, acc);
        check("lat_ready_full", tx_ready_a, 0);
        check("lat_idle_busy", busy_a, 0);
        check("lat_txd_n", txd_a, 1);
        @(negedge clk);
        check("lat_ready_freed", tx_ready_a, 1);
        check("lat_busy", busy_a, 1);
        check("lat_txd_n1", txd_a, 1);
        @(negedge clk);
        check("lat_start_bit", txd_a, 0);
        wait_frames(0, 1);

        // Back-to-back frames: second start bit directly after first stop bit
        b2b_before = b2b[0];
        send(0, 9'h03C, acc);
        send(0, 9'h0C3, acc);
        wait_frames(0, 3);
        check("b2b_no_gap", b2b[0] - b2b_before, 1);

        // Pending byte blocked by tx_enable = 0; extra tx_valid is ignored
        @(negedge clk);
        tx_enable_a = 1'b0;
        send(0, 9'h05A, acc);
        tx_data_a  = 8'hEE;
        tx_valid_a = 1'b1;
        ok_a = 1'b1;
        ok_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_ready_a !== 1'b0) ok_a = 1'b0;
            if (txd_a !== 1'b1 || busy_a !== 1'b0) ok_b = 1'b0;
        end
        tx_valid_a = 1'b0;
        check("pend_ready_low", ok_a, 1);
        check("pend_line_idle", ok_b, 1);
        tx_enable_a = 1'b1;
        @(negedge clk);
        check("en_busy", busy_a, 1);
        check("en_txd_high", txd_a, 1);
        @(negedge clk);
        check("en_start_bit", txd_a, 0);
        // Dropping enable mid-frame must not cut the frame short
        repeat (10) @(negedge clk);
        tx_enable_a = 1'b0;
        wait_frames(0, 4);
        tx_enable_a = 1'b1;

        // Instance B: 5 data bits, 2 stop bits
        send(1, 9'h015, acc);
        wait_frames(1, 1);

        // Reset during data bit 3 with a byte pending
        send(0, 9'h096, acc);
        send(0, 9'h011, acc2);
        t = 0;
        while (cyc < acc + 18 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_state_data", dbg_state_a, 5'b00100);
        #1;
        rst = 1'b1;
        exp_qa.delete();
        #1;
        check("rst_mid_txd", txd_a, 1);
        check("rst_mid_ready", tx_ready_a, 1);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_done", frame_done_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ok_a = 1'b1;
        ok_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_done_a !== 1'b0) ok_a = 1'b0;
            if (txd_a !== 1'b1) ok_b = 1'b0;
        end
        check("post_rst_no_done", ok_a, 1);
        check("post_rst_line_idle", ok_b, 1);
        check("post_rst_frames", frames[0], 4);

        // Fresh frame after reset, then two random bytes
        send(0, 9'h0E7, acc);
        wait_frames(0, 5);
        for (int i = 0; i < 2; i++) begin
            send(0, 9'($urandom_range(0, 255)), acc);
        end
        wait_frames(0, 7);
        check("queue_drained", exp_qa.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
